// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_VECTOR = '0;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             inst;
  } fetch_entry;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush wins over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry               wrData,
  output fetch_entry               rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry     mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= wrData;
  end

  assign rdData = mem[rdPtr];
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credited memory requests, buffers responses for decode.
// Optional misaligned-redirect halt is enabled with FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_misaligned
`endif
);

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     CREDITS   = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] INST_STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] respPc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifoCount;
  logic [CW:0]     credSum;
  logic            halted;
  logic            misalignedTarget;
  logic [XLEN-1:0] targetPc;
  logic            reqFire;
  logic            respKeep;
  logic            fifoPush;
  logic            fifoPop;
  logic            fifoEmpty;
  logic            fifoFull;
  fetch_entry      wrEntry;
  fetch_entry      headEntry;

`ifdef FETCH_ALIGN_CHECK_EN
  assign targetPc         = redirect_pc;
  assign misalignedTarget = |redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n)              halted <= 1'b0;
    else if (redirect_valid) halted <= misalignedTarget;
  end

  assign fetch_misaligned = halted;
`else
  logic unusedLowBits;
  assign unusedLowBits    = ^redirect_pc[1:0];
  assign targetPc         = {redirect_pc[XLEN-1:2], 2'b00};
  assign misalignedTarget = 1'b0;
  assign halted           = misalignedTarget;
`endif

  // Both interfaces use valid/ready: a transfer happens in any cycle where valid and ready
  // are both high; the producer keeps payload stable while valid is held without ready.
  // Credits count buffered entries plus every outstanding request, stale ones included,
  // so a response can never arrive to a full buffer.
  assign credSum        = {1'b0, fifoCount} + {1'b0, inflight};
  assign imem_req_valid = rst_n && !redirect_valid && (credSum < CREDITS) && !halted;
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign respKeep = imem_resp_valid && (drop == '0) && !redirect_valid;
  assign fifoPop  = inst_valid && inst_ready;
  assign fifoPush = respKeep && (!fifoFull || fifoPop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchPc  <= RESET_VECTOR;
      respPc   <= RESET_VECTOR;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(reqFire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetchPc <= targetPc;
        respPc  <= targetPc;
        drop    <= inflight - CW'(imem_resp_valid);
      end else begin
        if (reqFire) fetchPc <= fetchPc + INST_STEP;
        if (imem_resp_valid) begin
          if (drop != '0) drop   <= drop - CW'(1);
          else            respPc <= respPc + INST_STEP;
        end
      end
    end
  end

  assign wrEntry.pc   = respPc;
  assign wrEntry.inst = imem_resp_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (fifoPush),
    .pop    (fifoPop),
    .flush  (redirect_valid),
    .wrData (wrEntry),
    .rdData (headEntry),
    .count  (fifoCount),
    .empty  (fifoEmpty),
    .full   (fifoFull)
  );

  assign inst_valid = !fifoEmpty;
  assign inst_data  = headEntry.inst;
  assign inst_pc    = headEntry.pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage that replaces the free-running PC register in the single-cycle datapath. It owns the program counter and issues requests to instruction memory over a valid/ready interface with multi-cycle in-order responses. It buffers returned instructions with their PCs in a small FIFO and hands them to decode over valid/ready. It accepts branch/jump redirects and flushes all stale work.

Parameters:
XLEN, 32, address/PC width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request this cycle.
imem_req_addr  output  XLEN  word address of request (bits [1:0] always 0).
imem_resp_valid  input  1  one response per accepted request, in order, at least 1 cycle after acceptance.
imem_resp_data  input  32  instruction word.
redirect_valid  input  1  branch/jump taken; single-cycle pulse.
redirect_pc  input  XLEN  redirect target.
inst_valid  output  1  head of buffer valid.
inst_ready  input  1  decode consumes head.
inst_data  output  32  instruction at head.
inst_pc  output  XLEN  PC of inst_data.
fetch_misaligned  output  1  present only with FETCH_ALIGN_CHECK_EN.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n); sampled only at posedge clk.
- Reset: fetch_pc = resp_pc = RESET_VECTOR; FIFO empty; inflight = drop = 0. Outputs: imem_req_valid = 0, inst_valid = 0, fetch_misaligned = 0. Reset mid-operation discards all in-flight responses. Responses arriving in the first cycle after reset are the memory's responsibility; the bench does not drive them.
- Credit: imem_req_valid = rst_n && !redirect_valid && (fifo_count + inflight < FIFO_DEPTH) && !halted. imem_req_addr = fetch_pc.
- On accept (valid & ready): fetch_pc += 4 with XLEN wrap-around (all-ones-minus-3 wraps to 0); inflight += 1.
- imem_req_valid may drop without acceptance. Address stays stable while valid is held.
- Response handling: each imem_resp_valid decrements inflight.
  - If drop > 0: discard the response and decrement drop.
  - Otherwise: push {resp_pc, imem_resp_data} into the FIFO and advance resp_pc by 4.
- Simultaneous accept and response: inflight is unchanged.
- Output: inst_valid = !empty; inst_data and inst_pc come from the head. Pop on inst_valid & inst_ready.
- Push and pop in the same cycle: count is unchanged; legal when full because the credit rule prevents overflow.
- Redirect (highest priority): same cycle, imem_req_valid is forced 0.
- Next cycle after redirect:
  - fetch_pc = resp_pc = redirect_pc.
  - FIFO is flushed.
  - drop = inflight minus any response in the redirect cycle.
  - Any response in the redirect cycle is discarded.
  - A pop in the redirect cycle is a completed transfer.
- First request to the new target can issue the cycle after the redirect.
- Latency: request at cycle N, response at N+k, inst_valid at N+k+1 when the FIFO was empty.
- Back-to-back redirects: the last one wins; drop accumulates correctly.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: a redirect with redirect_pc[1:0] != 0 still flushes and sets drop, then sets halted = 1 and fetch_misaligned = 1. No requests issue until a redirect with an aligned target clears both. Reset clears both.
- Undefined: the fetch_misaligned port is absent; redirect_pc[1:0] is forced to 0; halted is constant 0.

Decomposition:
- fetch_pkg: XLEN default, INST_BYTES = 4, DEFAULT_RESET_VECTOR, and a fetch_entry struct {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry with push, pop, flush, count, empty and full. Parametrised by depth; synchronous active-low reset.

Test Plan:
1. Reset with RESET_VECTOR = 0x100, memory ready always, 1-cycle response, inst_ready = 1 -> requests to 0x100, 0x104, 0x108 on consecutive cycles; inst_pc sequence 0x100, 0x104, ... one per cycle.
2. inst_ready = 0 with FIFO_DEPTH = 4 -> exactly 4 requests accepted, then imem_req_valid = 0. Holding 1 cycle later resumes at 0x110 with no lost or duplicate entry.
3. 3-cycle memory latency with 2 requests in flight, redirect_pc = 0x200 -> both stale responses dropped; first inst_pc = 0x200; FIFO contents before the redirect never appear.
4. Redirect in the same cycle as imem_resp_valid and inst_ready -> the response is discarded, the head pop counts, and the next output is the 0x200 data.
5. fetch_pc = 0xFFFF_FFFC accepted -> next imem_req_addr = 0x0000_0000.
6. rst_n low for 1 cycle with 2 in flight and the FIFO full -> outputs 0 next cycle; fetch restarts at RESET_VECTOR. With FETCH_ALIGN_CHECK_EN, redirect to 0x202 -> fetch_misaligned = 1 and no requests until a redirect to 0x300.
